// File: rtl/vlc_pack_rr.sv
// Round-robin VLC merger: packs NCH show-ahead code FIFOs into MSB-first OUT_W-bit words.
// Define VLC_BITCNT_EN to add the saturating vlc_total_bits counter output.
module vlc_pack_rr #(
    parameter int NCH    = 4,
    parameter int CODE_W = 16,
    parameter int LEN_W  = 5,
    parameter int OUT_W  = 32
) (
    input  logic                    clk,
    input  logic                    rstN,
    input  logic                    vlc_glue_start,
    output logic                    vlc_glue_done,
    input  logic                    src_empty,
    input  logic                    src_end,
    input  logic [NCH-1:0]          vlc_empty,
    input  logic [NCH*LEN_W-1:0]    vlc_len,
    input  logic [NCH*CODE_W-1:0]   vlc_code,
    output logic [NCH-1:0]          vlc_rd,
    output logic [OUT_W-1:0]        vlc_glue_data,
    output logic                    vlc_glue_valid,
    input  logic                    vlc_glue_ready,
    output logic                    vlc_glue_last,
    output logic [$clog2(OUT_W):0]  vlc_glue_nbits,
    output logic                    vlc_len_err,
`ifdef VLC_BITCNT_EN
    output logic [31:0]             vlc_total_bits,
`endif
    output logic [1:0]              dbg_state
);

    localparam int ACC_W  = OUT_W + CODE_W;
    localparam int FILL_W = $clog2(ACC_W + 1);
    localparam int PTR_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int NB_W   = $clog2(OUT_W) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [FILL_W-1:0]  fill_q, fill_d, fill_ae;
    logic [ACC_W-1:0]   acc_q, acc_d, acc_ae, ins_bits;
    logic [OUT_W-1:0]   data_q, data_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;
    logic [NB_W-1:0]    nbits_q, nbits_d;
    logic               err_q, err_d;
    logic [NCH-1:0]     rd_c;

    logic [LEN_W-1:0]   cur_len, eff_len;
    logic [CODE_W-1:0]  cur_code, code_mask, code_aligned;
    logic               cur_empty, too_long;
    logic               out_free, end_cond, flush_now, emit, pflush, consume;

`ifdef VLC_BITCNT_EN
    logic [31:0]        bits_q, bits_d;
    logic [32:0]        bits_sum;
`endif

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        fill_d   = fill_q;
        acc_d    = acc_q;
        data_d   = data_q;
        valid_d  = valid_q;
        last_d   = last_q;
        nbits_d  = nbits_q;
        err_d    = err_q;
        rd_c     = '0;
        cur_len  = '0;
        cur_code = '0;
        cur_empty = 1'b1;
`ifdef VLC_BITCNT_EN
        bits_d   = bits_q;
        bits_sum = '0;
`endif

        out_free  = !valid_q || vlc_glue_ready;
        end_cond  = src_end && src_empty && (&vlc_empty);
        // A word emitted in the cycle RUN sees the end condition is already the final one.
        flush_now = (state_q == S_FLUSH) || ((state_q == S_RUN) && end_cond);

        for (int i = 0; i < NCH; i++) begin
            if (ptr_q == PTR_W'(i)) begin
                cur_len   = vlc_len[i*LEN_W +: LEN_W];
                cur_code  = vlc_code[i*CODE_W +: CODE_W];
                cur_empty = vlc_empty[i];
            end
        end

        too_long     = cur_len > LEN_W'(CODE_W);
        eff_len      = too_long ? LEN_W'(CODE_W) : cur_len;
        // Wraps to all-ones when eff_len == CODE_W.
        code_mask    = (CODE_W'(1) << eff_len) - CODE_W'(1);
        code_aligned = (cur_code & code_mask) << (LEN_W'(CODE_W) - eff_len);

        if (valid_q && vlc_glue_ready) begin
            valid_d = 1'b0;
        end

        fill_ae = fill_q;
        acc_ae  = acc_q;
        emit    = (fill_q >= FILL_W'(OUT_W)) && out_free;
        pflush  = (state_q == S_FLUSH) && (fill_q != '0) && (fill_q < FILL_W'(OUT_W)) && out_free;

        if (emit) begin
            data_d  = acc_q[ACC_W-1 -: OUT_W];
            valid_d = 1'b1;
            nbits_d = NB_W'(OUT_W);
            fill_ae = fill_q - FILL_W'(OUT_W);
            acc_ae  = acc_q << OUT_W;
            last_d  = flush_now && (fill_ae == '0);
        end else if (pflush) begin
            data_d  = acc_q[ACC_W-1 -: OUT_W];
            valid_d = 1'b1;
            nbits_d = NB_W'(fill_q);
            last_d  = 1'b1;
            fill_ae = '0;
            acc_ae  = '0;
        end

        ins_bits = {code_aligned, {OUT_W{1'b0}}} >> fill_ae;
        consume  = (state_q == S_RUN) && !cur_empty && (fill_ae < FILL_W'(OUT_W));

        fill_d = fill_ae;
        acc_d  = acc_ae;

        if (consume) begin
            rd_c   = NCH'(1) << ptr_q;
            acc_d  = acc_ae | ins_bits;
            fill_d = fill_ae + FILL_W'(eff_len);
            ptr_d  = (ptr_q == PTR_W'(NCH - 1)) ? '0 : ptr_q + 1'b1;
            if (too_long) begin
                err_d = 1'b1;
            end
`ifdef VLC_BITCNT_EN
            bits_sum = {1'b0, bits_q} + 33'(eff_len);
            bits_d   = bits_sum[32] ? 32'hFFFF_FFFF : bits_sum[31:0];
`endif
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (vlc_glue_start) begin
                    state_d = S_RUN;
                    ptr_d   = '0;
                    fill_d  = '0;
                    acc_d   = '0;
                    err_d   = 1'b0;
`ifdef VLC_BITCNT_EN
                    bits_d  = '0;
`endif
                end
            end
            S_RUN: begin
                if (end_cond) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if ((fill_q == '0) && !valid_q) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            fill_q  <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            nbits_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            fill_q  <= fill_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            nbits_q <= nbits_d;
            err_q   <= err_d;
        end
    end

`ifdef VLC_BITCNT_EN
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            bits_q <= '0;
        end else begin
            bits_q <= bits_d;
        end
    end

    assign vlc_total_bits = bits_q;
`endif

    assign vlc_rd         = rd_c;
    assign vlc_glue_data  = data_q;
    assign vlc_glue_valid = valid_q;
    assign vlc_glue_last  = last_q;
    assign vlc_glue_nbits = nbits_q;
    assign vlc_len_err    = err_q;
    assign vlc_glue_done  = (state_q == S_DONE);
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_vlc_pack_rr.sv
// Bench for vlc_pack_rr: directed scenarios plus random blocks against a bit-queue reference model.
// Connects vlc_total_bits when VLC_BITCNT_EN is defined.
module tb_vlc_pack_rr;

    localparam int NCH    = 4;
    localparam int CODE_W = 16;
    localparam int LEN_W  = 5;
    localparam int OUT_W  = 32;
    localparam int NB_W   = 6;

    logic                   clk = 1'b0;
    logic                   rstN;
    logic                   vlc_glue_start;
    logic                   vlc_glue_done;
    logic                   src_empty;
    logic                   src_end;
    logic [NCH-1:0]         vlc_empty;
    logic [NCH*LEN_W-1:0]   vlc_len;
    logic [NCH*CODE_W-1:0]  vlc_code;
    logic [NCH-1:0]         vlc_rd;
    logic [OUT_W-1:0]       vlc_glue_data;
    logic                   vlc_glue_valid;
    logic                   vlc_glue_ready;
    logic                   vlc_glue_last;
    logic [NB_W-1:0]        vlc_glue_nbits;
    logic                   vlc_len_err;
    logic [1:0]             dbg_state;
`ifdef VLC_BITCNT_EN
    logic [31:0]            vlc_total_bits;
`endif

    vlc_pack_rr #(.NCH(NCH), .CODE_W(CODE_W), .LEN_W(LEN_W), .OUT_W(OUT_W)) dut (
        .clk            (clk),
        .rstN           (rstN),
        .vlc_glue_start (vlc_glue_start),
        .vlc_glue_done  (vlc_glue_done),
        .src_empty      (src_empty),
        .src_end        (src_end),
        .vlc_empty      (vlc_empty),
        .vlc_len        (vlc_len),
        .vlc_code       (vlc_code),
        .vlc_rd         (vlc_rd),
        .vlc_glue_data  (vlc_glue_data),
        .vlc_glue_valid (vlc_glue_valid),
        .vlc_glue_ready (vlc_glue_ready),
        .vlc_glue_last  (vlc_glue_last),
        .vlc_glue_nbits (vlc_glue_nbits),
        .vlc_len_err    (vlc_len_err),
`ifdef VLC_BITCNT_EN
        .vlc_total_bits (vlc_total_bits),
`endif
        .dbg_state      (dbg_state)
    );

    always #5 clk = ~clk;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int cyc       = 0;

    // Block contents in consumption order; code k lives in channel k mod NCH.
    logic [LEN_W-1:0]  blk_len[$];
    logic [CODE_W-1:0] blk_code[$];
    int                pcnt[NCH];
    bit [NCH-1:0]      gate;
    bit                rand_mode;
    int                exp_ch, pop_cnt, first_pop, last_pop;
    bit                exp_err;
    longint            exp_bits;
    // {data[31:0], nbits[5:0], last}
    logic [38:0]       exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        int idx;
        int left;
        left = 0;
        for (int i = 0; i < NCH; i++) begin
            idx = i + NCH * pcnt[i];
            if (idx < blk_len.size()) begin
                vlc_len[i*LEN_W +: LEN_W]   = blk_len[idx];
                vlc_code[i*CODE_W +: CODE_W] = blk_code[idx];
                vlc_empty[i] = gate[i];
                left += blk_len.size() - idx;
            end else begin
                vlc_len[i*LEN_W +: LEN_W]   = '0;
                vlc_code[i*CODE_W +: CODE_W] = '0;
                vlc_empty[i] = 1'b1;
            end
        end
        src_empty = (left == 0);
        src_end   = (left == 0);
    endtask

    // Reference: flatten every code into a bit queue, then cut it into words.
    task automatic build_exp();
        bit          bq[$];
        int          eff, n;
        logic [31:0] w;
        exp_q.delete();
        exp_err  = 1'b0;
        exp_bits = 0;
        for (int k = 0; k < blk_len.size(); k++) begin
            eff = (blk_len[k] > 16) ? 16 : int'(blk_len[k]);
            if (blk_len[k] > 16) exp_err = 1'b1;
            exp_bits += eff;
            for (int b = eff - 1; b >= 0; b--) bq.push_back(blk_code[k][b]);
        end
        while (bq.size() > 0) begin
            n = (bq.size() < 32) ? bq.size() : 32;
            w = '0;
            for (int j = 0; j < n; j++) w[31-j] = bq.pop_front();
            exp_q.push_back({w, 6'(n), (bq.size() == 0)});
        end
    endtask

    task automatic tick();
        logic [NCH-1:0] rd_s;
        logic [38:0]    e;
        @(negedge clk);
        rd_s = vlc_rd;
        if (rd_s != '0) chk("rd_onehot", 64'($countones(rd_s)), 1);
        for (int i = 0; i < NCH; i++) begin
            if (rd_s[i]) begin
                chk("rr_order", i, exp_ch);
                chk("rd_on_empty", vlc_empty[i], 0);
                exp_ch = (exp_ch + 1) % NCH;
                pcnt[i]++;
                pop_cnt++;
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
            end
        end
        if (vlc_glue_valid && vlc_glue_ready) begin
            chk("word_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("word_data", vlc_glue_data, e[38:7]);
                chk("word_nbits", vlc_glue_nbits, e[6:1]);
                chk("word_last", vlc_glue_last, e[0]);
            end
        end
        cyc++;
        @(posedge clk);
        #1;
        if (rand_mode) begin
            for (int i = 0; i < NCH; i++) gate[i] = ($urandom_range(0, 99) < 30);
            vlc_glue_ready = ($urandom_range(0, 99) < 70);
        end
        drive();
    endtask

    task automatic new_block();
        blk_len.delete();
        blk_code.delete();
        gate           = '0;
        rand_mode      = 1'b0;
        vlc_glue_ready = 1'b1;
    endtask

    task automatic add_code(input int len, input int code);
        blk_len.push_back(LEN_W'(len));
        blk_code.push_back(CODE_W'(code));
    endtask

    task automatic start_block();
        build_exp();
        for (int i = 0; i < NCH; i++) pcnt[i] = 0;
        exp_ch    = 0;
        pop_cnt   = 0;
        first_pop = -1;
        last_pop  = -1;
        vlc_glue_start = 1'b1;
        drive();
        tick();
        vlc_glue_start = 1'b0;
    endtask

    task automatic finish_block(input int budget);
        int n;
        n = 0;
        while (!vlc_glue_done && n < budget) begin
            tick();
            n++;
        end
        chk("done", vlc_glue_done, 1);
        chk("words_left", exp_q.size(), 0);
        chk("pop_total", pop_cnt, blk_len.size());
        chk("len_err", vlc_len_err, exp_err);
`ifdef VLC_BITCNT_EN
        chk("total_bits", vlc_total_bits, exp_bits);
`endif
    endtask

    task automatic add_t1_codes();
        add_code(16, 'hAAAA); add_code(16, 'h5555);
        add_code(16, 'h1234); add_code(16, 'hFFFF);
    endtask

    initial begin
        rstN           = 1'b0;
        vlc_glue_start = 1'b0;
        new_block();
        for (int i = 0; i < NCH; i++) pcnt[i] = 0;
        drive();
        repeat (3) @(posedge clk);
        #1 rstN = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_valid", vlc_glue_valid, 0);
        chk("rst_done", vlc_glue_done, 0);
        chk("rst_rd", vlc_rd, 0);
        chk("rst_data", vlc_glue_data, 0);
        chk("rst_nbits", vlc_glue_nbits, 0);
        chk("rst_last", vlc_glue_last, 0);
        chk("rst_err", vlc_len_err, 0);
        chk("rst_state", dbg_state, 0);

        // Four full-length codes give exactly two words, one code per cycle.
        new_block();
        add_t1_codes();
        start_block();
        finish_block(200);
        chk("t1_throughput", last_pop - first_pop, 3);

        // 33 bits: one full word and a one-bit tail.
        new_block();
        add_code(11, 'h7FF); add_code(11, 'h000); add_code(11, 'h7FF);
        start_block();
        finish_block(200);

        // Output held back: the register plus a full accumulator stop the pops.
        new_block();
        add_t1_codes();
        add_code(16, 'h0F0F); add_code(16, 'hF0F0);
        add_code(16, 'h0001); add_code(16, 'h8000);
        vlc_glue_ready = 1'b0;
        start_block();
        repeat (6) tick();
        chk("t3_hold_data_a", vlc_glue_data, 32'hAAAA5555);
        repeat (4) tick();
        chk("t3_pops_stalled", pop_cnt, 4);
        chk("t3_hold_valid", vlc_glue_valid, 1);
        chk("t3_hold_data_b", vlc_glue_data, 32'hAAAA5555);
        chk("t3_hold_nbits", vlc_glue_nbits, 32);
        vlc_glue_ready = 1'b1;
        drive();
        finish_block(300);

        // Channel 1 dry while 2 and 3 hold data: nothing may be skipped.
        new_block();
        add_t1_codes();
        add_code(8, 'hC3); add_code(4, 'h9); add_code(16, 'h7E7E); add_code(3, 'h5);
        gate[1] = 1'b1;
        start_block();
        repeat (5) tick();
        chk("t4_wait_ch1", pop_cnt, 1);
        gate[1] = 1'b0;
        drive();
        finish_block(300);

        // Zero-length code and an over-long code.
        new_block();
        add_code(0, 'h1234); add_code(20, 'hFFFF);
        start_block();
        finish_block(200);
        repeat (3) tick();
        chk("t5_err_sticky", vlc_len_err, 1);

        // Reset with 17 bits buffered, then a fresh run.
        new_block();
        add_code(16, 'hABCD); add_code(1, 'h1); add_code(8, 'hFF); add_code(16, 'h0F0F);
        gate[2] = 1'b1;
        start_block();
        chk("t6_err_cleared", vlc_len_err, 0);
        repeat (3) tick();
        chk("t6_pops_before_rst", pop_cnt, 2);
        gate[2] = 1'b0;
        drive();
        #2 rstN = 1'b0;
        #1;
        chk("t6_rst_rd", vlc_rd, 0);
        chk("t6_rst_valid", vlc_glue_valid, 0);
        chk("t6_rst_state", dbg_state, 0);
        chk("t6_rst_done", vlc_glue_done, 0);
        repeat (2) @(posedge clk);
        #1 rstN = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_idle_after", dbg_state, 0);
        new_block();
        add_t1_codes();
        start_block();
        finish_block(200);

        // Random blocks with random channel stalls and output backpressure.
        for (int b = 0; b < 8; b++) begin
            int n;
            new_block();
            n = $urandom_range(1, 40);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 9) == 0) add_code($urandom_range(17, 31), $urandom_range(0, 65535));
                else add_code($urandom_range(0, 16), $urandom_range(0, 65535));
            end
            rand_mode = 1'b1;
            start_block();
            finish_block(3000);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
